// File: rtl/reg_write_demux_pkg.sv
// Shared widths, the write-request record and a helper for the register-0 discard rule
// used by the writeback demux and its decoder.
package reg_write_demux_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Writes to register 0 are dropped when it is hardwired to zero.
  function automatic logic is_discarded(input logic [ADDR_W-1:0] addr, input logic zeroReg);
    return zeroReg && (addr == '0);
  endfunction

endpackage

// File: rtl/reg_write_demux_decode_5to32.sv
// Combinational 5-to-32 one-hot decoder with enable.
// A disabled decoder produces an all-zero vector.
module decode_5to32
  import reg_write_demux_pkg::*;
(
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [REG_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_demux.sv
// Writeback demux: buffers (address, data) writes in a small FIFO and commits one
// per cycle into a 32-entry register array exposed flat to the read-select trees.
module reg_write_demux
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       hold,
  input  logic [ADDR_W-1:0]          query_addr,
  output logic                       query_hit,
  output logic                       commit_valid,
  output logic [ADDR_W-1:0]          commit_addr,
  output logic [REG_COUNT-1:0]       commit_onehot,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [REG_COUNT*WIDTH-1:0] regs_flat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } req_t;

  req_t                 queue_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [WIDTH-1:0]     regs_q [REG_COUNT];
  logic                 commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0]    commit_addr_q, commit_addr_d;
  logic [REG_COUNT-1:0] commit_onehot_q, commit_onehot_d;

  logic                 full, push, pop, wrEn, hit;
  logic [REG_COUNT-1:0] wrOnehot;
  logic [PTR_W-1:0]     offset;
  req_t                 headReq;

  // Ready is held high through reset so upstream never sees a stale full flag.
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full || !reset;
  assign push     = in_valid && !full;
  assign pop      = (count_q != '0) && !hold;
  assign headReq  = queue_q[head_q];
  assign wrEn     = pop && !is_discarded(headReq.addr, ZERO_EN);

  decode_5to32 u_decode (
    .en_i     (wrEn),
    .addr_i   (headReq.addr),
    .onehot_o (wrOnehot)
  );

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_valid_d  = pop;
    commit_addr_d   = commit_addr_q;
    commit_onehot_d = commit_onehot_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      commit_addr_d   = headReq.addr;
      commit_onehot_d = wrOnehot;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_addr_q   <= '0;
      commit_onehot_q <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_addr_q   <= commit_addr_d;
      commit_onehot_q <= commit_onehot_d;
    end
  end

  // Queue storage needs no reset; validity comes solely from head/count.
  always_ff @(posedge clock) begin
    if (push) begin
      queue_q[tail_q] <= '{addr: in_addr, data: in_data};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wrOnehot[r]) regs_q[r] <= headReq.data;
      end
    end
  end

  // Hazard probe over live entries; an entry is live if it sits within count of head.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (({1'b0, offset} < count_q) && (queue_q[i].addr == query_addr)) hit = 1'b1;
    end
  end

  assign query_hit = hit && !is_discarded(query_addr, ZERO_EN);

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_flat
    assign regs_flat[r*WIDTH +: WIDTH] = regs_q[r];
  end

  assign commit_valid  = commit_valid_q;
  assign commit_addr   = commit_addr_q;
  assign commit_onehot = commit_onehot_q;
  assign pending       = count_q;

endmodule

// File: tb/tb_reg_write_demux.sv
// Directed bench for reg_write_demux: a queue-based reference model is compared against
// the DUT every cycle, plus hand-computed literal expectations at key points.
module tb_reg_write_demux;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          hold = 1'b0;
  logic [4:0]    in_addr = '0;
  logic [4:0]    query_addr = '0;
  logic [31:0]   in_data = '0;
  logic          in_ready, query_hit, commit_valid;
  logic [4:0]    commit_addr;
  logic [31:0]   commit_onehot;
  logic [1:0]    pending;
  logic [1023:0] regs_flat;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t        mq[$];
  logic [31:0] mRegs [32];
  logic        mCommitValid = 1'b0;
  logic [4:0]  mCommitAddr = '0;
  logic [31:0] mCommitOnehot = '0;

  int passCount = 0;
  int totalCount = 0;
  bit checkEn = 1'b0;

  reg_write_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .hold          (hold),
    .query_addr    (query_addr),
    .query_hit     (query_hit),
    .commit_valid  (commit_valid),
    .commit_addr   (commit_addr),
    .commit_onehot (commit_onehot),
    .pending       (pending),
    .regs_flat     (regs_flat)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Reference behaviour at one clock edge: drain the head into the register file, then queue the new request.
  task automatic modelEdge();
    req_t h;
    logic doPush, doPop;
    if (!reset) begin
      mq.delete();
      for (int r = 0; r < 32; r++) mRegs[r] = '0;
      mCommitValid  = 1'b0;
      mCommitAddr   = '0;
      mCommitOnehot = '0;
    end else begin
      doPush = in_valid && (mq.size() < DEPTH);
      doPop  = (mq.size() != 0) && !hold;
      mCommitValid = doPop;
      if (doPop) begin
        h = mq.pop_front();
        mCommitAddr = h.addr;
        if (h.addr == 5'd0) mCommitOnehot = '0;
        else begin
          mCommitOnehot  = 32'd1 << h.addr;
          mRegs[h.addr]  = h.data;
        end
      end
      if (doPush) mq.push_back('{addr: in_addr, data: in_data});
    end
  endtask

  function automatic logic modelHit();
    logic h = 1'b0;
    foreach (mq[i]) if (mq[i].addr == query_addr) h = 1'b1;
    return h && (query_addr != 5'd0);
  endfunction

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    hold     = h;
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    int bad;
    if (checkEn) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!reset || (mq.size() < DEPTH)));
      checkOutput("pending", 32'(pending), 32'(mq.size()));
      checkOutput("query_hit", 32'(query_hit), 32'(modelHit()));
      checkOutput("commit_valid", 32'(commit_valid), 32'(mCommitValid));
      checkOutput("commit_addr", 32'(commit_addr), 32'(mCommitAddr));
      checkOutput("commit_onehot", commit_onehot, mCommitOnehot);
      bad = -1;
      for (int r = 0; r < 32; r++) begin
        if ((regs_flat[r*32 +: 32] !== mRegs[r]) && (bad < 0)) bad = r;
      end
      totalCount++;
      if (bad < 0) passCount++;
      else $display("[TB] FAIL regs_flat reg%0d: got 0x%08h, expected 0x%08h",
                    bad, regs_flat[bad*32 +: 32], mRegs[bad]);
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) mRegs[r] = '0;

    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset commit_valid", 32'(commit_valid), 32'd0);
    reset = 1'b1;

    // Single write: accepted at one edge, committed at the next.
    applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    checkOutput("no same-edge commit", regs_flat[7*32 +: 32], 32'd0);
    checkOutput("single pending", 32'(pending), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("single reg7", regs_flat[7*32 +: 32], 32'hDEADBEEF);
    checkOutput("single commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("single onehot", commit_onehot, 32'h0000_0080);
    checkOutput("single commit_addr", 32'(commit_addr), 32'd7);
    checkOutput("model reg7", mRegs[7], 32'hDEADBEEF);

    // Register 0 discard.
    query_addr = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    checkOutput("reg0 pending", 32'(pending), 32'd1);
    checkOutput("reg0 query_hit", 32'(query_hit), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("reg0 stays zero", regs_flat[31:0], 32'd0);
    checkOutput("reg0 commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("reg0 onehot", commit_onehot, 32'd0);

    // Backpressure: fill under hold, then drain in order.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1);
    checkOutput("full pending", 32'(pending), 32'd2);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1);
    checkOutput("held pending", 32'(pending), 32'd2);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0);
    checkOutput("drain1 reg1", regs_flat[1*32 +: 32], 32'h11);
    checkOutput("drain1 pending", 32'(pending), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0);
    checkOutput("drain2 reg2", regs_flat[2*32 +: 32], 32'h22);
    checkOutput("drain2 pending", 32'(pending), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("drain3 reg3", regs_flat[3*32 +: 32], 32'h33);
    checkOutput("drain3 pending", 32'(pending), 32'd0);

    // Ordering and hazard on the same address.
    query_addr = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'h1, 1'b1);
    applyStimulus(1'b1, 5'd5, 32'h2, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("hazard hit", 32'(query_hit), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("hazard reg5 first", regs_flat[5*32 +: 32], 32'h1);
    checkOutput("hazard hit remains", 32'(query_hit), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("hazard reg5 last", regs_flat[5*32 +: 32], 32'h2);
    checkOutput("hazard hit cleared", 32'(query_hit), 32'd0);

    // Steady stream of 40 writes.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 5'(i % 32), 32'(i), 1'b0);
      checkOutput("stream pending<=1", 32'(pending <= 2'd1), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("stream reg7", regs_flat[7*32 +: 32], 32'd39);
    checkOutput("stream reg8", regs_flat[8*32 +: 32], 32'd8);
    checkOutput("stream reg31", regs_flat[31*32 +: 32], 32'd31);
    checkOutput("stream reg0", regs_flat[31:0], 32'd0);

    // Reset mid-operation drops queued writes.
    applyStimulus(1'b1, 5'd9, 32'hAA, 1'b1);
    applyStimulus(1'b1, 5'd10, 32'hBB, 1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("midreset pending", 32'(pending), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("midreset commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("midreset regs zero", 32'(regs_flat == '0), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("midreset reg9", regs_flat[9*32 +: 32], 32'd0);
    checkOutput("midreset reg10", regs_flat[10*32 +: 32], 32'd0);

    @(negedge clock);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
